// File: rtl/fifo_byte_packer.sv
// Pops bytes from an upstream sync FIFO and packs BYTES_PER_WORD of them little-endian
// into one word on a valid/ready output. Define PACK_FLUSH_EN to flush idle partial words.
module fifo_byte_packer #(
    parameter int FIFO_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int FLUSH_CYCLES   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_,
    input  logic                                 fifo_empty,
    input  logic [FIFO_WIDTH-1:0]                fifo_data_out,
    output logic                                 fifo_read,
    output logic [FIFO_WIDTH*BYTES_PER_WORD-1:0] word_out,
    output logic [BYTES_PER_WORD-1:0]            word_be,
    output logic                                 word_valid,
    input  logic                                 word_ready
);

    localparam int CW = $clog2(BYTES_PER_WORD) + 1;
    localparam int WW = FIFO_WIDTH * BYTES_PER_WORD;
    localparam logic [CW-1:0] NBYTES = CW'(BYTES_PER_WORD);
    localparam logic [CW-1:0] LAST   = CW'(BYTES_PER_WORD - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    if ((BYTES_PER_WORD < 2) || (BYTES_PER_WORD > 4) || (FLUSH_CYCLES < 1)) begin : g_bad_cfg
        $error("fifo_byte_packer: BYTES_PER_WORD must be 2..4 and FLUSH_CYCLES >= 1");
    end

    logic [0:0]                state_q, state_d;
    logic [CW-1:0]             issued_q, issued_d;
    logic [CW-1:0]             cap_idx_q, cap_idx_d;
    logic                      rd_pend_q, rd_pend_d;
    logic [WW-1:0]             word_q, word_d;
    logic [BYTES_PER_WORD-1:0] be_q, be_d;
    logic                      valid_q, valid_d;

`ifdef PACK_FLUSH_EN
    localparam int IW = $clog2(FLUSH_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        // Gated by rst_ so no pop can escape while the packer is held in reset.
        fifo_read = rst_ && (state_q == S_FILL) && !fifo_empty && (issued_q < NBYTES);
        state_d   = state_q;
        issued_d  = issued_q;
        cap_idx_d = cap_idx_q;
        rd_pend_d = fifo_read;
        word_d    = word_q;
        be_d      = be_q;
        valid_d   = valid_q;
`ifdef PACK_FLUSH_EN
        idle_d    = '0;
`endif
        if (fifo_read) issued_d = issued_q + 1'b1;

        case (state_q)
            S_FILL: begin
                if (rd_pend_q) begin
                    for (int l = 0; l < BYTES_PER_WORD; l++) begin
                        if (cap_idx_q == CW'(l)) word_d[l*FIFO_WIDTH +: FIFO_WIDTH] = fifo_data_out;
                    end
                    cap_idx_d = cap_idx_q + 1'b1;
                    if (cap_idx_q == LAST) begin
                        valid_d = 1'b1;
                        be_d    = '1;
                        state_d = S_HOLD;
                    end
                end
`ifdef PACK_FLUSH_EN
                // Only a settled partial word ages; any read keeps the counter at zero.
                if ((cap_idx_q != '0) && !rd_pend_q && fifo_empty) begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == IW'(FLUSH_CYCLES)) begin
                        idle_d  = '0;
                        valid_d = 1'b1;
                        for (int l = 0; l < BYTES_PER_WORD; l++) be_d[l] = (CW'(l) < cap_idx_q);
                        state_d = S_HOLD;
                    end
                end
`endif
            end
            default: begin
                if (valid_q && word_ready) begin
                    valid_d   = 1'b0;
                    issued_d  = '0;
                    cap_idx_d = '0;
                    word_d    = '0;
                    be_d      = '0;
                    state_d   = S_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= S_FILL;
            issued_q  <= '0;
            cap_idx_q <= '0;
            rd_pend_q <= 1'b0;
            word_q    <= '0;
            be_q      <= '0;
            valid_q   <= 1'b0;
`ifdef PACK_FLUSH_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            cap_idx_q <= cap_idx_d;
            rd_pend_q <= rd_pend_d;
            word_q    <= word_d;
            be_q      <= be_d;
            valid_q   <= valid_d;
`ifdef PACK_FLUSH_EN
            idle_q    <= idle_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_be    = be_q;
    assign word_valid = valid_q;

endmodule
